// File: rtl/add16_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : add16_accumulator_if
// Purpose  : Control, operand and result handshake bundle for add16_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface add16_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             clear;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             sign;
    logic             parity;
    logic             busy;

    modport slave (
        input  clear, start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero, sign, parity, busy
    );

    modport master (
        output clear, start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero, sign, parity, busy
    );
endinterface
`default_nettype wire

// File: rtl/add16_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : add16_accumulator
// Purpose  : Sums a run of LEN operands with sticky carry/overflow status and
//            hands the result downstream over valid/ready.
//            Define ADD16_ACC_SATURATE_EN for signed saturating accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module add16_accumulator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    add16_accumulator_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_fire;
    logic             w_run_start;
    logic [WIDTH:0]   w_sum_full;
    logic             w_ovf_add;
    logic [WIDTH-1:0] w_acc_add;

    // ------------------------------------------------------------------
    // Adder datapath
    // ------------------------------------------------------------------
    assign w_sum_full = {1'b0, r_acc} + {1'b0, bus.in_data};
    assign w_ovf_add  = (r_acc[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                        (w_sum_full[WIDTH-1] != r_acc[WIDTH-1]);

`ifdef ADD16_ACC_SATURATE_EN
    // On overflow both addends share a sign, so the accumulator's sign picks the rail
    assign w_acc_add = !w_ovf_add       ? w_sum_full[WIDTH-1:0] :
                       r_acc[WIDTH-1]   ? {1'b1, {(WIDTH-1){1'b0}}} :
                                          {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_acc_add = w_sum_full[WIDTH-1:0];
`endif

    assign w_fire      = (r_state == c_ST_ACCUM) && bus.in_valid;
    assign w_run_start = (r_state == c_ST_IDLE) && bus.start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = (bus.len != '0) ? c_ST_ACCUM : c_ST_DONE;
                    end
                end
                c_ST_ACCUM: begin
                    if (w_fire && (r_cnt == CNT_W'(1))) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_ST_ACCUM: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            c_ST_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator, operand counter and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.clear) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_run_start) begin
            r_acc   <= '0;
            r_cnt   <= bus.len;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_fire) begin
            r_acc   <= w_acc_add;
            r_cnt   <= r_cnt - CNT_W'(1);
            r_carry <= r_carry | w_sum_full[WIDTH];
            r_ovf   <= r_ovf | w_ovf_add;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_acc;
    assign bus.sign      = r_acc[WIDTH-1];
    assign bus.zero      = (r_acc == '0);
    assign bus.parity    = ~^r_acc;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add16_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_add16_accumulator
// Purpose  : Self-checking bench: directed table, corner sequences, random runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add16_accumulator;

    logic clk;
    logic rst_n;

    add16_accumulator_if #(.WIDTH(16), .CNT_W(8)) bus ();

    add16_accumulator #(.WIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] ops [4];
        logic [15:0] e_sum;
        bit          e_c;
        bit          e_o;
        bit          bub;
        int          hold;
    } vec_t;

    vec_t tbl [7];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int n,
                           input logic [15:0] o0, input logic [15:0] o1,
                           input logic [15:0] o2, input logic [15:0] o3,
                           input logic [15:0] s, input bit c, input bit o,
                           input bit bub, input int hold);
        tbl[idx].n      = n;
        tbl[idx].ops[0] = o0;
        tbl[idx].ops[1] = o1;
        tbl[idx].ops[2] = o2;
        tbl[idx].ops[3] = o3;
        tbl[idx].e_sum  = s;
        tbl[idx].e_c    = c;
        tbl[idx].e_o    = o;
        tbl[idx].bub    = bub;
        tbl[idx].hold   = hold;
    endtask

    // Reference: arithmetic on integers, overflow judged from the true signed sum
    task automatic model(input logic [15:0] ops[$], output logic [15:0] s,
                         output bit c, output bit o);
        logic [15:0] acc;
        int          us;
        int          ss;
        acc = 16'h0;
        c   = 1'b0;
        o   = 1'b0;
        foreach (ops[i]) begin
            us = int'(acc) + int'(ops[i]);
            ss = int'($signed(acc)) + int'($signed(ops[i]));
            if (us > 65535) c = 1'b1;
            if (ss > 32767 || ss < -32768) begin
                o = 1'b1;
`ifdef ADD16_ACC_SATURATE_EN
                us = (ss > 0) ? 32'h7FFF : 32'h8000;
`endif
            end
            acc = us[15:0];
        end
        s = acc;
    endtask

    task automatic run(input string tag, input logic [15:0] ops[$], input bit bub,
                       input int hold, input logic [15:0] es, input bit ec, input bit eo);
        int n;
        n = ops.size();
        bus.start = 1'b1;
        bus.len   = 8'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (n == 0) begin
            chk({tag, " len0 out_valid"}, 32'(bus.out_valid), 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            if (bub) begin
                repeat ($urandom_range(1, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.start    = 1'b1;
                    bus.len      = 8'd9;
                    chk({tag, " bubble in_ready"}, 32'(bus.in_ready), 32'd1);
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = ops[i];
            chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_data  = 16'($urandom);
            chk({tag, " out_valid timing"}, 32'(bus.out_valid), (i == n - 1) ? 32'd1 : 32'd0);
        end
        chk({tag, " in_ready done"}, 32'(bus.in_ready), 32'd0);
        chk({tag, " busy done"}, 32'(bus.busy), 32'd1);
        chk({tag, " sum"}, 32'(bus.sum), 32'(es));
        chk({tag, " carry"}, 32'(bus.carry), 32'(ec));
        chk({tag, " overflow"}, 32'(bus.overflow), 32'(eo));
        chk({tag, " zero"}, 32'(bus.zero), 32'(es == 16'h0));
        chk({tag, " sign"}, 32'(bus.sign), 32'(es[15]));
        chk({tag, " parity"}, 32'(bus.parity), 32'(~^es));
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            chk({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " hold sum"}, 32'(bus.sum), 32'(es));
            chk({tag, " hold flags"}, {28'd0, bus.carry, bus.overflow, bus.zero, bus.parity},
                {28'd0, ec, eo, es == 16'h0, ~^es});
        end
        // A start coinciding with the result handshake must not launch a run
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = 8'd5;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk({tag, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " sum"}, 32'(bus.sum), 32'd0);
        chk({tag, " flags"}, {27'd0, bus.carry, bus.overflow, bus.zero, bus.sign, bus.parity},
            {27'd0, 5'b00101});
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] es;
        bit          ec;
        bit          eo;

        n_vec = 0;
        n_bad = 0;

        set_vec(0, 3, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0006, 0, 0, 0, 0);
        set_vec(1, 2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 5);
`ifdef ADD16_ACC_SATURATE_EN
        set_vec(2, 2, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 0, 1, 0, 0);
        set_vec(5, 2, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 1, 1, 0, 1);
`else
        set_vec(2, 2, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 0, 1, 0, 0);
        set_vec(5, 2, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 1);
`endif
        set_vec(3, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
        set_vec(4, 4, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h4000, 0, 0, 1, 2);
        set_vec(6, 1, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 0, 0, 0, 0);

        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Operands offered in IDLE must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        chk("idle in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk_reset_vals("idle ignore");

        foreach (tbl[k]) begin
            q.delete();
            for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].ops[i]);
            run($sformatf("tbl%0d", k), q, tbl[k].bub, tbl[k].hold,
                tbl[k].e_sum, tbl[k].e_c, tbl[k].e_o);
        end

        // clear mid-run after 2 of 4 operands
        bus.start = 1'b1;
        bus.len   = 8'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h4000;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.clear    = 1'b1;
        @(posedge clk); #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        chk_reset_vals("clear midrun");
        q = '{16'h0005, 16'h0006};
        run("after clear", q, 0, 0, 16'h000B, 0, 0);

        // clear while the result is presented
        q = '{16'hFFFF, 16'hFFFF};
        bus.start = 1'b1;
        bus.len   = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        foreach (q[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = q[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("pre-clear out_valid", 32'(bus.out_valid), 32'd1);
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        chk_reset_vals("clear done");

        // asynchronous reset mid-run, checked before any further clock edge
        bus.start = 1'b1;
        bus.len   = 8'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h8001;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        q = '{16'h0100, 16'h0200, 16'h0300};
        run("after rst", q, 0, 0, 16'h0600, 0, 0);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0:       q.push_back(16'h7FFF);
                    1:       q.push_back(16'h8000);
                    2:       q.push_back(16'hFFFF);
                    default: q.push_back(16'($urandom));
                endcase
            end
            model(q, es, ec, eo);
            run($sformatf("rand%0d", r), q, bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), es, ec, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
